// File: rtl/nibble_arith_pkg.sv
// Shared definitions for the nibble-serial arithmetic blocks: controller states,
// nibble width and the index-width helper.
package nibble_arith_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width of a nibble index; a single-nibble datapath still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n_nib);
    return (n_nib > 1) ? $clog2(n_nib) : 1;
  endfunction

endpackage

// File: rtl/adder_4bit.sv
// Purely combinational 4-bit adder with carry in/out; the one arithmetic
// resource shared across all nibbles of an operation.
module adder_4bit
  import nibble_arith_pkg::*;
(
  input  logic [NIB_W-1:0] ina,
  input  logic [NIB_W-1:0] inb,
  input  logic             carry_in,
  output logic [NIB_W-1:0] sum_out,
  output logic             carry_out
);

  logic [NIB_W:0] full;

  always_comb begin
    full      = {1'b0, ina} + {1'b0, inb} + {{NIB_W{1'b0}}, carry_in};
    sum_out   = full[NIB_W-1:0];
    carry_out = full[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences one shared 4-bit adder over WIDTH-bit operands, LSB nibble first,
// with a registered ripple carry and valid/ready handshakes on both sides.
module nibble_serial_adder_ctrl
  import nibble_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned N_NIB = WIDTH / NIB_W;
  localparam int unsigned IDX_W = idx_width(N_NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_carry;

  always_comb begin
    nib_a = a_q[idx*NIB_W +: NIB_W];
    nib_b = b_q[idx*NIB_W +: NIB_W];
  end

  adder_4bit u_adder (
    .ina       (nib_a),
    .inb       (nib_b),
    .carry_in  (carry_q),
    .sum_out   (nib_sum),
    .carry_out (nib_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Subtraction is A + ~B + 1: B is stored inverted and the carry seeds the +1.
            a_q      <= op_a;
            b_q      <= sub ? ~op_b : op_b;
            carry_q  <= sub ? 1'b1 : carry_in;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum[idx*NIB_W +: NIB_W] <= nib_sum;
          carry_q   <= nib_carry;
          carry_out <= nib_carry;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          // No accept in this transition: in_ready only rises once IDLE is reached.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed bench for nibble_serial_adder_ctrl (WIDTH=16) against
// a plain-arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N_NIB = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: modulo-2^WIDTH arithmetic; for subtraction carry means A >= B (no borrow).
  task automatic ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic ci,
                        output logic [WIDTH-1:0] es, output logic ec);
    int unsigned ia, ib, full;
    ia = a;
    ib = b;
    if (s) begin
      es = WIDTH'(ia - ib);
      ec = (ia >= ib);
    end else begin
      full = ia + ib + ci;
      es   = WIDTH'(full);
      ec   = (full >= (1 << WIDTH));
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic ci);
    logic [WIDTH-1:0] es;
    logic             ec;
    int               cnt;
    ref_op(a, b, s, ci, es, ec);
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    op_a     = a;
    op_b     = b;
    sub      = s;
    carry_in = ci;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = WIDTH'($urandom);
    op_b     = WIDTH'($urandom);
    sub      = 1'($urandom);
    carry_in = 1'($urandom);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(N_NIB + 1));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_carry"}, 32'(carry_out), 32'(ec));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] held_sum;
    logic             held_carry;
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic             qs[$];
    logic             qc[$];
    int               acc_cyc[$];
    int               n_acc, n_res, cyc;
    bit               pulse;
    logic [WIDTH-1:0] es;
    logic             ec;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    carry_in  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add", 16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op("ripple2", 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    run_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1);
    run_op("sub2", 16'h8000, 16'h0001, 1'b1, 1'b0);
    run_op("sub_eq", 16'hA5A5, 16'hA5A5, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      run_op($sformatf("rnd%0d", i), WIDTH'($urandom), WIDTH'($urandom),
             1'($urandom), 1'($urandom));

    // Backpressure with ignored in_valid while busy.
    op_a = 16'h0102; op_b = 16'h0304; sub = 1'b0; carry_in = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    held_sum   = sum;
    held_carry = carry_out;
    check("bp_sum", 32'(held_sum), 32'h0406);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op_a = WIDTH'($urandom);
      op_b = WIDTH'($urandom);
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'(held_sum));
      check("bp_hold_carry", 32'(carry_out), 32'(held_carry));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_rel_in_ready", 32'(in_ready), 32'd1);
    check("bp_rel_out_valid", 32'(out_valid), 32'd0);
    check("bp_rel_busy", 32'(busy), 32'd0);
    check("bp_rel_sum_kept", 32'(sum), 32'(held_sum));

    // Reset during the second RUN cycle.
    op_a = 16'hFFFF; op_b = 16'hFFFF; sub = 1'b0; carry_in = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    pulse = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) pulse = 1'b1;
    end
    check("mid_rst_no_pulse", 32'(pulse), 32'd0);
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    // Back-to-back with in_valid held and out_ready high.
    out_ready = 1'b1;
    n_acc = 0;
    n_res = 0;
    cyc   = 0;
    while (n_res < 3 && cyc < 60) begin
      if (out_valid) begin
        if (qa.size() == 0) begin
          check("b2b_unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          ref_op(qa.pop_front(), qb.pop_front(), qs.pop_front(), qc.pop_front(), es, ec);
          check($sformatf("b2b_sum%0d", n_res), 32'(sum), 32'(es));
          check($sformatf("b2b_carry%0d", n_res), 32'(carry_out), 32'(ec));
        end
        n_res++;
      end
      op_a     = WIDTH'($urandom);
      op_b     = WIDTH'($urandom);
      sub      = 1'($urandom);
      carry_in = 1'($urandom);
      in_valid = (n_acc < 3);
      if (in_valid && in_ready) begin
        qa.push_back(op_a);
        qb.push_back(op_b);
        qs.push_back(sub);
        qc.push_back(carry_in);
        acc_cyc.push_back(cyc);
        n_acc++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_results", 32'(n_res), 32'd3);
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(N_NIB + 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
